// File: rtl/cipher_pkg.sv
// Shared types, default parameters and helpers for the multi-lane shift-cipher engine.
package cipher_pkg;

  localparam int unsigned DEF_N         = 8;
  localparam int unsigned DEF_LANES     = 4;
  localparam int unsigned DEF_M         = 26;
  localparam int unsigned DEF_SW        = 5;
  localparam int unsigned DEF_KEY_DEPTH = 16;

  typedef enum logic [1:0] {
    DIR_PASS = 2'b00,
    DIR_DEC  = 2'b01,
    DIR_ENC  = 2'b10
  } dir_e;

  // Remainder of value by modulus; a zero modulus leaves the value untouched.
  function automatic logic [31:0] mod_reduce(input logic [31:0] value,
                                             input logic [31:0] modulus);
    return (modulus == 32'd0) ? value : (value % modulus);
  endfunction

  // Raw direction code 2'b11 is treated the same as pass.
  function automatic dir_e decode_dir(input logic [1:0] code);
    dir_e d;
    case (code)
      2'b01:   d = DIR_DEC;
      2'b10:   d = DIR_ENC;
      default: d = DIR_PASS;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_lane.sv
// Combinational per-symbol shift: encrypt, decrypt or pass modulo M.
module shift_lane
  import cipher_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned M = DEF_M
) (
  input  logic [N-1:0] d,
  input  logic [N-1:0] s_eff,
  input  dir_e         dir,
  output logic [N-1:0] result,
  output logic         oor
);

  localparam logic [N:0] MOD = (N+1)'(M);

  logic [N:0] sum;
  logic [N:0] wrap;

  // Symbols outside the alphabet are flagged and never shifted.
  always_comb begin
    sum    = {1'b0, d} + {1'b0, s_eff};
    wrap   = {1'b0, d} + MOD - {1'b0, s_eff};
    oor    = ({1'b0, d} >= MOD);
    result = d;
    if (!oor) begin
      case (dir)
        DIR_ENC: result = (sum >= MOD) ? N'(sum - MOD) : N'(sum);
        DIR_DEC: result = (d >= s_eff) ? (d - s_eff) : N'(wrap);
        default: result = d;
      endcase
    end
  end

endmodule

// File: rtl/shift_cipher_engine.sv
// Two-stage multi-lane shift cipher with Caesar/Vigenere shift selection,
// a loadable key table and valid/ready handshakes on both sides.
module shift_cipher_engine
  import cipher_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned M         = DEF_M,
  parameter int unsigned SW        = DEF_SW,
  parameter int unsigned KEY_DEPTH = DEF_KEY_DEPTH,
  localparam int unsigned KAW      = $clog2(KEY_DEPTH),
  localparam int unsigned DW       = LANES * N
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       direction,
  input  logic             vig,
  input  logic [SW-1:0]    shift,
  input  logic             key_we,
  input  logic [KAW-1:0]   key_addr,
  input  logic [SW-1:0]    key_wdata,
  input  logic [KAW:0]     key_len,
  input  logic             key_restart,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    dout,
  output logic [LANES-1:0] oor
);

  logic [SW-1:0]    key_mem [KEY_DEPTH];
  logic [KAW-1:0]   ptr;
  logic [KAW-1:0]   ptr_base;
  logic [KAW-1:0]   ptr_next;
  logic [KAW:0]     key_len_eff;
  logic [KAW-1:0]   lane_idx [LANES];
  logic [SW-1:0]    lane_raw [LANES];
  logic [DW-1:0]    lane_shift;

  logic             advance;
  logic             accept;

  logic             s1_valid;
  logic [DW-1:0]    s1_din;
  logic [DW-1:0]    s1_shift;
  dir_e             s1_dir;

  logic [DW-1:0]    lane_result;
  logic [LANES-1:0] lane_oor;

  // The whole pipeline moves together, so one advance strobe covers both stages.
  assign advance  = en & (~out_valid | out_ready);
  assign in_ready = advance;
  assign accept   = in_valid & advance;

  // Effective key length, pointer base and per-lane shift selection.
  always_comb begin
    key_len_eff = key_len;
    if (key_len == '0) begin
      key_len_eff = (KAW+1)'(1);
    end else if (key_len > (KAW+1)'(KEY_DEPTH)) begin
      key_len_eff = (KAW+1)'(KEY_DEPTH);
    end

    ptr_base = key_restart ? '0 : KAW'(mod_reduce(32'(ptr), 32'(key_len_eff)));
    ptr_next = vig ? KAW'(mod_reduce(32'(ptr_base) + 32'(LANES), 32'(key_len_eff)))
                   : ptr_base;

    lane_shift = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_idx[i] = KAW'(mod_reduce(32'(ptr_base) + 32'(i), 32'(key_len_eff)));
      lane_raw[i] = vig ? key_mem[lane_idx[i]] : shift;
      lane_shift[i*N +: N] = N'(mod_reduce(32'(lane_raw[i]), 32'(M)));
    end
  end

  // Key table: a write lands at the clock edge, so a same-cycle read sees the old entry.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KEY_DEPTH; i++) begin
        key_mem[i] <= '0;
      end
    end else if (en && key_we) begin
      key_mem[key_addr] <= key_wdata;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en) begin
      if (accept) begin
        ptr <= ptr_next;
      end else if (key_restart) begin
        ptr <= '0;
      end
    end
  end

  // Stage 1: captured symbols, resolved shifts and direction.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_din   <= '0;
      s1_shift <= '0;
      s1_dir   <= DIR_PASS;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_din   <= din;
        s1_shift <= lane_shift;
        s1_dir   <= decode_dir(direction);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    shift_lane #(
      .N (N),
      .M (M)
    ) u_lane (
      .d      (s1_din[g*N +: N]),
      .s_eff  (s1_shift[g*N +: N]),
      .dir    (s1_dir),
      .result (lane_result[g*N +: N]),
      .oor    (lane_oor[g])
    );
  end

  // Stage 2: registered results; held while the sink stalls or en is low.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      oor       <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dout <= lane_result;
        oor  <= lane_oor;
      end
    end
  end

endmodule

// File: doc/shift_cipher_engine.md
# shift_cipher_engine

Parametrised, pipelined shift-cipher engine: the multi-lane successor to the single-byte `decryption` block. Each beat carries LANES symbols. It encrypts, decrypts or passes them through modulo an alphabet size M. Shifts come from either a single global shift value (Caesar mode) or a loadable key table that advances per symbol (Vigenère mode). Sits between the byte source and the output sink, with valid/ready on both sides.

## Interface
- N, 8, symbol width in bits
- LANES, 4, symbols per beat
- M, 26, alphabet modulus (2..2^N)
- SW, 5, shift / key entry width
- KEY_DEPTH, 16, key table entries; KAW = $clog2(KEY_DEPTH)

- clock  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable; low freezes all state and forces in_ready=0
- direction  in  2  00 pass, 01 decrypt, 10 encrypt, 11 pass; sampled per accepted beat
- vig  in  1  0 = Caesar (`shift` for every lane), 1 = Vigenère (key table); sampled per beat
- shift  in  SW  Caesar shift
- key_we / key_addr / key_wdata  in  1 / KAW / SW  key table write port
- key_len  in  KAW+1  active key length; 0 is treated as 1; values above KEY_DEPTH are clamped
- key_restart  in  1  pulse; key pointer returns to 0
- in_valid / in_ready  in / out  1 / 1  input handshake
- din  in  LANES*N  lane i = din[i*N +: N]
- out_valid / out_ready  out / in  1 / 1  output handshake
- dout  out  LANES*N  result symbols
- oor  out  LANES  per-lane flag: input symbol ≥ M, passed through unchanged

## Operation
- Beat accepted when in_valid & in_ready. in_ready = en & (!s2_valid | out_ready), i.e. the pipeline advances as one unit.
- Shift reduction: s_eff = s mod M, computed on SW bits. Example: shift 26 with M=26 gives 0.
- Encrypt: t = d + s_eff on N+1 bits; result = (t ≥ M) ? t−M : t.
- Decrypt: result = (d ≥ s_eff) ? d − s_eff : d + M − s_eff.
- Pass, or symbol d ≥ M: result = d, and oor[i] is set (for pass, oor still reflects d ≥ M).
- Vigenère lane i uses key[(ptr + i) mod L], with L the effective key_len.
- ptr advances by LANES mod L per accepted beat with vig=1. It does not advance when vig=0.
- key_restart with an accepted beat in the same cycle: that beat uses ptr=0; ptr becomes LANES mod L.
- Key write to an entry read in the same cycle: the beat sees the old value; the new value is used from the next beat.
- Change of key_len: ptr is reduced mod the new L on the next accepted beat.

## Timing
- Latency 2 cycles. Stage 1 registers din and the per-lane shifts. Stage 2 registers the result, oor and out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Output stall (out_valid & !out_ready): dout, oor and out_valid hold stable; in_ready drops the same cycle.
- en low: no register updates and out_valid holds. Mid-stream resume continues without loss or duplication.
- Reset (asynchronous assert, synchronous release) sets:
  - out_valid=0, dout=0, oor=0
  - stage valids=0, ptr=0
  - all key entries=0
  - Data in flight is discarded.

## Structure
- Package `cipher_pkg` holds:
  - `dir_e` enum (DIR_PASS, DIR_DEC, DIR_ENC)
  - default parameter constants
  - the `mod_reduce` function
- Sub-module `shift_lane` is combinational. It takes d, s_eff and dir and produces result and oor. It is instantiated LANES times.
- The top holds the key table, pointer logic, pipeline registers and handshake.

## Test plan
- Caesar decrypt with defaults: din lanes {0x0B,0x00,0x19,0x1A}, shift 5, dir 01, vig 0 -> dout {0x06,0x15,0x14,0x1A}, oor=4'b1000, out_valid two cycles after accept.
- Encrypt sweep of shift 1,5,10,15,20,25,26 on din 0x0B -> 0x0C, 0x10, 0x15, 0x00, 0x05, 0x0A, 0x0B; then dir 01 on the results recovers 0x0B.
- Vigenère: key {3,1,4}, key_len 3, dir 10, two beats of all-zero din -> {3,1,4,3} then {1,4,3,1}; key_restart before beat 2 -> {3,1,4,3} again.
- Backpressure: out_ready held low 5 cycles with in_valid=1 -> at most 2 beats in flight, dout stable, no beat lost or duplicated, in order.
- en low for 3 cycles mid-stream, and key write to the in-use entry during a beat -> frozen outputs, then old key value used for that beat.
- Reset asserted with 2 beats in flight -> out_valid, dout and ptr are 0 immediately (asynchronously); the first beat after release uses key[0].
